seg7_scan_ctrl: RTL and testbench

//  Time-multiplexed scan controller for an 8-digit common-anode 7-segment display.

---
 rtl/seg7_scan_ctrl_if.sv | 14 +
 rtl/seg7_scan_ctrl.sv | 142 ++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_ctrl_if.sv
// Digit-register write bus for seg7_scan_ctrl.
//   wr_en   : write strobe, one digit register written per clock
//   wr_addr : digit index, 0 = rightmost digit (an[0]), 7 = leftmost
//   wr_data : 4-bit BCD value (10..15 stored unchanged)
// The master (host) drives all three signals and the slave (display controller) samples them.
// There is no back-pressure: a write is accepted in every cycle where wr_en is high.
interface seg7_scan_ctrl_if;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [3:0] wr_data;

  modport master (output wr_en, wr_addr, wr_data);
  modport slave  (input  wr_en, wr_addr, wr_data);
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for an 8-digit common-anode 7-segment display.
// The module holds eight BCD digit registers, which are written through wr_bus. It drives one
// shared BCD-to-7-segment decoder (bcd, seg_en, seg7all_on) and eight active-low anode selects.
// Features: per-digit masking, leading-zero suppression, lamp test, and a blanking guard at
// the start of each slot. The guard keeps the old digit's segments from ghosting onto the new
// anode.
// Ports:
//   clk, rst     : clock and synchronous active-high reset
//   wr_bus       : digit register write port (slave side)
//   digit_mask   : 1 = digit i displayed, 0 = anode i held off in its slot
//   lz_suppress  : 1 = blank leading zeros (digit 0 always shown)
//   lamp_test    : 1 = light all segments on every digit
//   bcd          : value sent to the decoder (always digit[idx], even when blanked)
//   seg_en       : decoder enable
//   seg7all_on   : decoder all-segments-on
//   an           : active-low anode selects, at most one low
//   frame_tick   : one-clock pulse after the last clock of slot 7
// All outputs are registered. The value in cycle t+1 is decoded from the state and the inputs
// of cycle t.
module seg7_scan_ctrl #(
  parameter int DIV_MAX      = 50000,
  parameter int BLANK_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  seg7_scan_ctrl_if.slave   wr_bus,
  input  logic [7:0]        digit_mask,
  input  logic              lz_suppress,
  input  logic              lamp_test,
  output logic [3:0]        bcd,
  output logic              seg_en,
  output logic              seg7all_on,
  output logic [7:0]        an,
  output logic              frame_tick
);

  localparam int            CW       = (DIV_MAX > 2) ? $clog2(DIV_MAX) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV_MAX - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [3:0]    digit_q [8];
  logic [3:0]    digit_d [8];

  logic [3:0]    bcd_q, bcd_d;
  logic          seg_en_q, seg_en_d;
  logic          seg7all_on_q, seg7all_on_d;
  logic [7:0]    an_q, an_d;
  logic          frame_tick_q, frame_tick_d;

  logic [7:0]    digit_zero;
  logic [7:0]    upper_zero;   // upper_zero[i]: digits i..7 are all zero
  logic          guard;

  // Per-digit write decode and zero detection.
  for (genvar gi = 0; gi < 8; gi++) begin : g_digit
    always_comb begin
      digit_d[gi] = digit_q[gi];
      if (wr_bus.wr_en && (wr_bus.wr_addr == 3'(gi))) begin
        digit_d[gi] = wr_bus.wr_data;
      end
    end
    assign digit_zero[gi] = (digit_q[gi] == 4'd0);
  end

  // Suffix AND chain from the leftmost digit downwards.
  assign upper_zero[7] = digit_zero[7];
  for (genvar gi = 0; gi < 7; gi++) begin : g_upper
    assign upper_zero[gi] = digit_zero[gi] & upper_zero[gi + 1];
  end

  // Anti-ghosting guard. It is never active when BLANK_CYCLES is 0, and this avoids an
  // always-false unsigned compare.
  if (BLANK_CYCLES == 0) begin : g_no_guard
    assign guard = 1'b0;
  end else begin : g_guard
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES);
    assign guard = (cnt_q < BLANK_LAST);
  end

  // Prescaler and slot index.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    idx_d = idx_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = idx_q + 3'd1;
    end
  end

  // Slot output decode. The checks are in priority order.
  always_comb begin
    an_d         = 8'hFF;
    seg_en_d     = 1'b0;
    seg7all_on_d = 1'b0;
    bcd_d        = digit_q[idx_q];
    frame_tick_d = (cnt_q == CNT_LAST) && (idx_q == 3'd7);
    if (guard) begin
      an_d = 8'hFF;
    end else if (lamp_test) begin
      an_d         = ~(8'h01 << idx_q);
      seg_en_d     = 1'b1;
      seg7all_on_d = 1'b1;
    end else if (!digit_mask[idx_q]) begin
      an_d = 8'hFF;
    end else if (lz_suppress && (idx_q != 3'd0) && upper_zero[idx_q]) begin
      an_d = 8'hFF;
    end else begin
      an_d     = ~(8'h01 << idx_q);
      seg_en_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      for (int i = 0; i < 8; i++) digit_q[i] <= '0;
      bcd_q        <= '0;
      seg_en_q     <= 1'b0;
      seg7all_on_q <= 1'b0;
      an_q         <= 8'hFF;
      frame_tick_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      for (int i = 0; i < 8; i++) digit_q[i] <= digit_d[i];
      bcd_q        <= bcd_d;
      seg_en_q     <= seg_en_d;
      seg7all_on_q <= seg7all_on_d;
      an_q         <= an_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign bcd        = bcd_q;
  assign seg_en     = seg_en_q;
  assign seg7all_on = seg7all_on_q;
  assign an         = an_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Testbench for seg7_scan_ctrl with DIV_MAX=8 and BLANK_CYCLES=2.
// On every clock the stimulus side predicts the next registered output and pushes it into a
// scoreboard queue. A monitor on the falling edge pops one entry per clock and compares it with
// the outputs. Directed checks add hand-computed expectations at key points in each scenario.
module tb_seg7_scan_ctrl;
  localparam int DIV   = 8;
  localparam int BLANK = 2;

  typedef struct packed {
    logic [7:0] an;
    logic       seg_en;
    logic       all_on;
    logic [3:0] bcd;
    logic       ft;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] digit_mask  = 8'hFF;
  logic       lz_suppress = 1'b0;
  logic       lamp_test   = 1'b0;
  logic [3:0] bcd;
  logic       seg_en, seg7all_on, frame_tick;
  logic [7:0] an;

  seg7_scan_ctrl_if wr_bus ();

  seg7_scan_ctrl #(.DIV_MAX(DIV), .BLANK_CYCLES(BLANK)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_bus      (wr_bus),
    .digit_mask  (digit_mask),
    .lz_suppress (lz_suppress),
    .lamp_test   (lamp_test),
    .bcd         (bcd),
    .seg_en      (seg_en),
    .seg7all_on  (seg7all_on),
    .an          (an),
    .frame_tick  (frame_tick)
  );

  always #5 clk = ~clk;

  int   vectors     = 0;
  int   miscompares = 0;
  exp_t sb [$];

  // Reference state: the value of cnt/idx/digits during the current cycle.
  int         m_cnt = 0;
  int         m_idx = 0;
  logic [3:0] m_dig [8];

  // Accumulators for the directed checks.
  logic [7:0] lit_acc;
  int         ft_acc;
  logic       all_on_seen;

  function automatic exp_t model_out();
    exp_t e;
    logic allz;
    e.an     = 8'hFF;
    e.seg_en = 1'b0;
    e.all_on = 1'b0;
    e.bcd    = m_dig[m_idx];
    e.ft     = (m_cnt == DIV - 1) && (m_idx == 7);
    allz     = 1'b1;
    for (int j = m_idx; j < 8; j++) if (m_dig[j] != 4'd0) allz = 1'b0;
    if (m_cnt < BLANK) begin
      e.an = 8'hFF;
    end else if (lamp_test) begin
      e.an = 8'hFF; e.an[m_idx] = 1'b0; e.seg_en = 1'b1; e.all_on = 1'b1;
    end else if (!digit_mask[m_idx]) begin
      e.an = 8'hFF;
    end else if (lz_suppress && m_idx != 0 && allz) begin
      e.an = 8'hFF;
    end else begin
      e.an = 8'hFF; e.an[m_idx] = 1'b0; e.seg_en = 1'b1;
    end
    return e;
  endfunction

  // Predict one clock, advance the model, and then let the clock edge happen.
  task automatic step();
    exp_t e;
    if (rst) begin
      e = '{an: 8'hFF, seg_en: 1'b0, all_on: 1'b0, bcd: 4'd0, ft: 1'b0};
      m_cnt = 0; m_idx = 0;
      for (int i = 0; i < 8; i++) m_dig[i] = 4'd0;
    end else begin
      e = model_out();
      if (wr_bus.wr_en) m_dig[wr_bus.wr_addr] = wr_bus.wr_data;
      if (m_cnt == DIV - 1) begin m_cnt = 0; m_idx = (m_idx + 1) % 8; end
      else m_cnt = m_cnt + 1;
    end
    sb.push_back(e);
    @(posedge clk); #1;
    lit_acc = lit_acc | ~an;
    if (frame_tick) ft_acc++;
    if (seg7all_on) all_on_seen = 1'b1;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic clear_acc();
    lit_acc = 8'h00; ft_acc = 0; all_on_seen = 1'b0;
  endtask

  task automatic wr(input logic [2:0] a, input logic [3:0] d);
    wr_bus.wr_en = 1'b1; wr_bus.wr_addr = a; wr_bus.wr_data = d;
    step();
    wr_bus.wr_en = 1'b0;
  endtask

  task automatic run_to(input int idx, input int cnt);
    for (int k = 0; k < 200 && !(m_idx == idx && m_cnt == cnt); k++) step();
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: one scoreboard entry per clock, compared away from the active edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      vectors++;
      if (an !== e.an || seg_en !== e.seg_en || seg7all_on !== e.all_on ||
          bcd !== e.bcd || frame_tick !== e.ft) begin
        miscompares++;
        $display("FAIL scan_out t=%0t: got an=%h en=%b all=%b bcd=%h ft=%b, expected an=%h en=%b all=%b bcd=%h ft=%b",
                 $time, an, seg_en, seg7all_on, bcd, frame_tick,
                 e.an, e.seg_en, e.all_on, e.bcd, e.ft);
      end
    end
  end

  initial begin
    wr_bus.wr_en = 1'b0; wr_bus.wr_addr = 3'd0; wr_bus.wr_data = 4'd0;
    for (int i = 0; i < 8; i++) m_dig[i] = 4'd0;
    clear_acc();

    // T1: reset held 3 clocks, then 2 guard clocks, then digit 0 shows 0.
    rst = 1'b1;
    run(3);
    check("reset_an", an, 8'hFF);
    check("reset_en", {7'd0, seg_en}, 8'h00);
    rst = 1'b0;
    run(2);
    check("guard_an", an, 8'hFF);
    step();
    check("first_slot_an", an, 8'hFE);
    check("first_slot_en", {7'd0, seg_en}, 8'h01);
    check("first_slot_bcd", {4'd0, bcd}, 8'h00);

    // T2: digit i = i+1. There are exactly two frame ticks in any 128 clocks.
    for (int i = 0; i < 8; i++) wr(3'(i), 4'(i + 1));
    clear_acc();
    run(128);
    check("scan_lit", lit_acc, 8'hFF);
    check("frame_ticks", 8'(ft_acc), 8'd2);

    // T3: leading-zero suppression.
    lz_suppress = 1'b1;
    for (int i = 0; i < 8; i++) wr(3'(i), (i == 2) ? 4'd1 : 4'd0);
    clear_acc();
    run(64);
    check("lz_lit_digit2", lit_acc, 8'h07);
    wr(3'd2, 4'd0);
    clear_acc();
    run(64);
    check("lz_lit_allzero", lit_acc, 8'h01);

    // T4: lamp test overrides the mask. The mask then blanks slots 4..7.
    lz_suppress = 1'b0; digit_mask = 8'h0F; lamp_test = 1'b1;
    clear_acc();
    run(64);
    check("lamp_lit", lit_acc, 8'hFF);
    check("lamp_all_on", {7'd0, all_on_seen}, 8'h01);
    lamp_test = 1'b0;
    clear_acc();
    run(64);
    check("mask_lit", lit_acc, 8'h0F);
    check("mask_all_on", {7'd0, all_on_seen}, 8'h00);

    // T5: live write into the displayed slot, then rst beats a simultaneous write.
    digit_mask = 8'hFF;
    run_to(3, 4);
    wr(3'd3, 4'd9);
    check("live_an_hold", an, 8'hF7);
    step();
    check("live_bcd", {4'd0, bcd}, 8'h09);
    check("live_an", an, 8'hF7);
    rst = 1'b1;
    wr(3'd3, 4'd5);
    rst = 1'b0;
    run_to(3, BLANK);
    step();
    check("rst_wr_bcd", {4'd0, bcd}, 8'h00);
    check("rst_wr_an", an, 8'hF7);

    // T6: reset in the middle of slot 5.
    wr(3'd5, 4'd7);
    run_to(5, 3);
    rst = 1'b1;
    step();
    check("midrst_an", an, 8'hFF);
    check("midrst_bcd", {4'd0, bcd}, 8'h00);
    rst = 1'b0;
    run(2);
    check("midrst_guard", an, 8'hFF);
    step();
    check("midrst_resume", an, 8'hFE);

    @(negedge clk);
    @(negedge clk);
    check("sb_drained", 8'(sb.size()), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
